// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised 2-read/1-write register file with a
// per-register busy scoreboard for RAW-hazard stalls in decode.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding of
// same-cycle writeback data and busy state onto the read ports).
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic                  busyA,
    output logic                  busyB,
    input  logic                  ctrl_issueEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_issueReg,
    input  logic                  ctrl_flush,
    output logic [ADDR_WIDTH:0]   busy_count,
    output logic                  err_doubleIssue
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int CW       = ADDR_WIDTH + 1;
    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_r;
    logic [NUM_REGS-1:0]   busy_nxt_s;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_nxt_s;
    logic                  err_r;
    logic                  err_nxt_s;

    logic                  we_eff_s;
    logic                  iss_eff_s;
    logic                  cnt_set_s;
    logic                  cnt_clr_s;
    logic                  dbl_issue_s;

    // Qualify write/issue strobes: a hardwired zero register absorbs both.
    always_comb begin
        we_eff_s  = ctrl_writeEnable;
        iss_eff_s = ctrl_issueEnable;
        if (HAS_ZERO && (ctrl_writeReg == ZERO_IDX)) begin
            we_eff_s = 1'b0;
        end else begin
            we_eff_s = ctrl_writeEnable;
        end
        if (HAS_ZERO && (ctrl_issueReg == ZERO_IDX)) begin
            iss_eff_s = 1'b0;
        end else begin
            iss_eff_s = ctrl_issueEnable;
        end
    end

    // Next busy vector: writeback clears, a later issue re-claims, flush wipes all.
    always_comb begin
        busy_nxt_s = busy_r;
        if (ctrl_flush) begin
            busy_nxt_s = {NUM_REGS{1'b0}};
        end else begin
            if (we_eff_s) begin
                busy_nxt_s[ctrl_writeReg] = 1'b0;
            end else begin
                busy_nxt_s = busy_r;
            end
            if (iss_eff_s) begin
                busy_nxt_s[ctrl_issueReg] = 1'b1;
            end else begin
                busy_nxt_s[ctrl_issueReg] = busy_nxt_s[ctrl_issueReg];
            end
        end
    end

    // Incremental popcount tracking and double-issue detection from current state.
    always_comb begin
        // A bit rises only if it was clear; it falls only if nothing re-claims it this cycle.
        cnt_set_s   = iss_eff_s && !busy_r[ctrl_issueReg];
        cnt_clr_s   = we_eff_s && busy_r[ctrl_writeReg] &&
                      !(iss_eff_s && (ctrl_issueReg == ctrl_writeReg));
        dbl_issue_s = iss_eff_s && busy_r[ctrl_issueReg] &&
                      !(we_eff_s && (ctrl_writeReg == ctrl_issueReg)) && !ctrl_flush;
        if (ctrl_flush) begin
            count_nxt_s = {CW{1'b0}};
            err_nxt_s   = 1'b0;
        end else begin
            count_nxt_s = count_r + CW'(cnt_set_s) - CW'(cnt_clr_s);
            err_nxt_s   = err_r | dbl_issue_s;
        end
    end

    // Register storage: async clear, writeback updates the addressed entry.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (we_eff_s) begin
            regs_r[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Scoreboard state, busy counter and sticky error flag.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            busy_r  <= {NUM_REGS{1'b0}};
            count_r <= {CW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            busy_r  <= busy_nxt_s;
            count_r <= count_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Read port A: stored state, optionally overridden by same-cycle writeback.
    always_comb begin
        data_readRegA = regs_r[ctrl_readRegA];
        busyA         = busy_r[ctrl_readRegA];
        if (HAS_ZERO && (ctrl_readRegA == ZERO_IDX)) begin
            data_readRegA = {DATA_WIDTH{1'b0}};
            busyA         = 1'b0;
`ifdef REGFILE_BYPASS_EN
        end else if (we_eff_s && (ctrl_writeReg == ctrl_readRegA)) begin
            data_readRegA = data_writeReg;
            busyA         = iss_eff_s && (ctrl_issueReg == ctrl_readRegA) && !ctrl_flush;
`endif
        end else begin
            data_readRegA = regs_r[ctrl_readRegA];
            busyA         = busy_r[ctrl_readRegA];
        end
    end

    // Read port B: identical to port A, independent index.
    always_comb begin
        data_readRegB = regs_r[ctrl_readRegB];
        busyB         = busy_r[ctrl_readRegB];
        if (HAS_ZERO && (ctrl_readRegB == ZERO_IDX)) begin
            data_readRegB = {DATA_WIDTH{1'b0}};
            busyB         = 1'b0;
`ifdef REGFILE_BYPASS_EN
        end else if (we_eff_s && (ctrl_writeReg == ctrl_readRegB)) begin
            data_readRegB = data_writeReg;
            busyB         = iss_eff_s && (ctrl_issueReg == ctrl_readRegB) && !ctrl_flush;
`endif
        end else begin
            data_readRegB = regs_r[ctrl_readRegB];
            busyB         = busy_r[ctrl_readRegB];
        end
    end

    assign busy_count      = count_r;
    assign err_doubleIssue = err_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;

    logic        clock;
    logic        ctrl_reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        busyA;
    logic        busyB;
    logic        ctrl_issueEnable;
    logic [4:0]  ctrl_issueReg;
    logic        ctrl_flush;
    logic [5:0]  busy_count;
    logic        err_doubleIssue;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
        .clock           (clock),
        .ctrl_reset_n    (ctrl_reset_n),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg   (ctrl_writeReg),
        .data_writeReg   (data_writeReg),
        .ctrl_readRegA   (ctrl_readRegA),
        .ctrl_readRegB   (ctrl_readRegB),
        .data_readRegA   (data_readRegA),
        .data_readRegB   (data_readRegB),
        .busyA           (busyA),
        .busyB           (busyB),
        .ctrl_issueEnable(ctrl_issueEnable),
        .ctrl_issueReg   (ctrl_issueReg),
        .ctrl_flush      (ctrl_flush),
        .busy_count      (busy_count),
        .err_doubleIssue (err_doubleIssue)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ctrl_writeEnable = 1'b0;
        ctrl_issueEnable = 1'b0;
        ctrl_flush       = 1'b0;
    endtask

    initial begin
        ctrl_reset_n     = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        ctrl_readRegA    = 5'd0;
        ctrl_readRegB    = 5'd0;
        ctrl_issueEnable = 1'b0;
        ctrl_issueReg    = 5'd0;
        ctrl_flush       = 1'b0;
        #22;
        ctrl_reset_n = 1'b1;
        tick();

        // Reset state across every index.
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            #1;
            check_eq("rst_dataA", data_readRegA, 64'd0);
            check_eq("rst_dataB", data_readRegB, 64'd0);
            check_eq("rst_busyA", busyA, 64'd0);
            check_eq("rst_busyB", busyB, 64'd0);
        end
        check_eq("rst_count", busy_count, 64'd0);
        check_eq("rst_err", err_doubleIssue, 64'd0);

        // Write r5, read on both ports next cycle.
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEADBEEF;
        tick();
        idle_inputs();
        ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd5;
        #1;
        check_eq("wr5_A", data_readRegA, 64'hDEADBEEF);
        check_eq("wr5_B", data_readRegB, 64'hDEADBEEF);

        // Write to hardwired r0 is dropped.
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'h1234;
        tick();
        idle_inputs();
        ctrl_readRegA = 5'd0;
        #1;
        check_eq("r0_zero", data_readRegA, 64'd0);

        // Issue r7 then writeback r7.
        ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd7;
        tick();
        idle_inputs();
        ctrl_readRegA = 5'd7;
        #1;
        check_eq("iss7_busyA", busyA, 64'd1);
        check_eq("iss7_count", busy_count, 64'd1);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h55;
        tick();
        idle_inputs();
        #1;
        check_eq("wb7_busyA", busyA, 64'd0);
        check_eq("wb7_count", busy_count, 64'd0);
        check_eq("wb7_data", data_readRegA, 64'h55);

        // Double issue to r3.
        ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd3;
        tick();
        check_eq("iss3_err0", err_doubleIssue, 64'd0);
        tick();
        idle_inputs();
        ctrl_readRegB = 5'd3;
        #1;
        check_eq("dbl3_err", err_doubleIssue, 64'd1);
        check_eq("dbl3_count", busy_count, 64'd1);
        check_eq("dbl3_busyB", busyB, 64'd1);

        // Same-cycle issue and write to r9: producer wins, not a double issue.
        ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd9;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h99;
        tick();
        idle_inputs();
        ctrl_readRegA = 5'd9;
        #1;
        check_eq("iw9_busyA", busyA, 64'd1);
        check_eq("iw9_data", data_readRegA, 64'h99);
        check_eq("iw9_count", busy_count, 64'd2);
        check_eq("iw9_err_sticky", err_doubleIssue, 64'd1);

        // Issue r4 together with flush: flush wins and clears the error.
        ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd4; ctrl_flush = 1'b1;
        tick();
        idle_inputs();
        ctrl_readRegA = 5'd4; ctrl_readRegB = 5'd3;
        #1;
        check_eq("fl_busyA", busyA, 64'd0);
        check_eq("fl_busyB", busyB, 64'd0);
        check_eq("fl_count", busy_count, 64'd0);
        check_eq("fl_err", err_doubleIssue, 64'd0);

        // Consecutive issues r1..r3, then issue r4 while writing r1.
        for (int i = 1; i <= 3; i++) begin
            ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'(i);
            tick();
            check_eq("seq_count", busy_count, 64'(i));
        end
        ctrl_issueReg = 5'd4;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd1; data_writeReg = 32'h11;
        tick();
        idle_inputs();
        check_eq("net0_count", busy_count, 64'd3);
        check_eq("net0_err", err_doubleIssue, 64'd0);

        // Flush, then claim every register (r0 included, which is ignored).
        ctrl_flush = 1'b1;
        tick();
        idle_inputs();
        check_eq("fl2_count", busy_count, 64'd0);
        for (int i = 0; i < 32; i++) begin
            ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'(i);
            tick();
        end
        idle_inputs();
        check_eq("full_count", busy_count, 64'd31);
        check_eq("full_err", err_doubleIssue, 64'd0);
        ctrl_readRegA = 5'd31; ctrl_readRegB = 5'd0;
        #1;
        check_eq("full_busyA", busyA, 64'd1);
        check_eq("full_busyB_r0", busyB, 64'd0);

        // Write-through behaviour on r6 while busy.
        ctrl_flush = 1'b1;
        tick();
        idle_inputs();
        ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd6;
        tick();
        idle_inputs();
        ctrl_readRegA = 5'd6;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd6; data_writeReg = 32'hA5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("byp_dataA", data_readRegA, 64'hA5A5);
        check_eq("byp_busyA", busyA, 64'd0);
`else
        check_eq("nobyp_dataA", data_readRegA, 64'd0);
        check_eq("nobyp_busyA", busyA, 64'd1);
`endif
        tick();
        idle_inputs();
        #1;
        check_eq("wb6_dataA", data_readRegA, 64'hA5A5);
        check_eq("wb6_busyA", busyA, 64'd0);

        // Asynchronous reset mid-burst: outputs clear without a clock edge.
        ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd12;
        tick();
        ctrl_issueReg = 5'd13;
        tick();
        idle_inputs();
        ctrl_readRegA = 5'd6; ctrl_readRegB = 5'd12;
        #1;
        check_eq("pre_rst_count", busy_count, 64'd2);
        check_eq("pre_rst_busyB", busyB, 64'd1);
        ctrl_reset_n = 1'b0;
        #1;
        check_eq("arst_dataA", data_readRegA, 64'd0);
        check_eq("arst_busyB", busyB, 64'd0);
        check_eq("arst_count", busy_count, 64'd0);
        ctrl_readRegA = 5'd5;
        #1;
        check_eq("arst_r5", data_readRegA, 64'd0);
        #3;
        ctrl_reset_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
